alu_ctrl_muldiv: RTL and testbench

Parametrised successor to the single-cycle ALU control decoder. It keeps the combinational ALUControl/load_store decode for RV32I and adds RV32M support: M-extension R-type instructions run on an iterative multiply/divide engine with a start/done handshake. The block sits in the execute stage beside the ALU. The control unit stalls the pipeline while `md_busy` is high.

---
 rtl/alu_ctrl_muldiv.sv | 181 ++++++++++++++++++
 tb/tb_alu_ctrl_muldiv.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_muldiv.sv
// ALU control decode for RV32I plus an iterative RV32M multiply/divide engine.
// M-ops take a fixed XLEN+1 cycles from the start edge to the md_done pulse.
module alu_ctrl_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic            op5,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [3:0]      ALUControl,
  output logic [2:0]      load_store,
  output logic            is_mop,
  output logic            md_busy,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  localparam logic [XLEN-1:0] CNT_LAST = XLEN - 1;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [XLEN-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic              dz_q, dz_d;
  logic              ovf_q, ovf_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              done_q, done_d;

  always_comb begin
    is_mop     = (ALUOp == 2'b10) & op5 & funct7_0;
    ALUControl = 4'b0000;
    load_store = 3'b000;
    case (ALUOp)
      2'b00: begin
        case (funct3)
          3'b000:  load_store = 3'b001;
          3'b001:  load_store = 3'b010;
          3'b100:  load_store = 3'b011;
          3'b101:  load_store = 3'b100;
          default: load_store = 3'b000;
        endcase
      end
      2'b01: ALUControl = 4'b0001;
      2'b10: begin
        if (!is_mop) begin
          case (funct3)
            3'b000:  ALUControl = (funct7_5 & op5) ? 4'b0001 : 4'b0000;
            3'b001:  ALUControl = 4'b0010;
            3'b010:  ALUControl = 4'b0011;
            3'b011:  ALUControl = 4'b0100;
            3'b100:  ALUControl = 4'b0101;
            3'b101:  ALUControl = {3'b011, op5};
            3'b110:  ALUControl = 4'b1000;
            default: ALUControl = 4'b1001;
          endcase
        end
      end
      default: ALUControl = 4'b0000;
    endcase
  end

  // Operands are reduced to magnitudes at launch; the sign is restored in FIX.
  logic            a_sgn, b_sgn;
  logic [XLEN-1:0] mag_a, mag_b;
  always_comb begin
    a_sgn = a[XLEN-1] & (funct3 == 3'b001 || funct3 == 3'b010 ||
                         funct3 == 3'b100 || funct3 == 3'b110);
    b_sgn = b[XLEN-1] & (funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b110);
    mag_a = a_sgn ? -a : a;
    mag_b = b_sgn ? -b : b;
  end

  // acc holds {product high, multiplier} for multiply and {remainder, quotient} for divide.
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, opb_q};
    div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    prod_fix  = neg_q ? -acc_q : acc_q;
    quo_fix   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix   = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:         fix_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         fix_result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101: fix_result = dz_q ? '1 : (ovf_q ? MIN_NEG : quo_fix);
      // A zero divisor leaves the dividend in the remainder, which re-signs back to a.
      default:        fix_result = ovf_q ? '0 : rem_fix;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && is_mop) state_d = S_RUN;
      S_RUN:   if (cnt_q == CNT_LAST) state_d = S_FIX;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    opb_d  = opb_q;
    acc_d  = acc_q;
    neg_d  = neg_q;
    dz_d   = dz_q;
    ovf_d  = ovf_q;
    res_d  = res_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && is_mop) begin
          cnt_d = '0;
          op_d  = funct3;
          opb_d = mag_b;
          acc_d = {{XLEN{1'b0}}, mag_a};
          neg_d = (funct3 == 3'b110) ? a_sgn : (a_sgn ^ b_sgn);
          dz_d  = (b == '0);
          ovf_d = (funct3 == 3'b100 || funct3 == 3'b110) && (a == MIN_NEG) && (b == '1);
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = op_q[2] ? div_next : mul_next;
      end
      default: begin
        res_d  = fix_result;
        done_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    md_busy   = (state_q == S_RUN) || (state_q == S_FIX);
    md_done   = done_q;
    md_result = res_q;
  end

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Directed bench for alu_ctrl_muldiv: decode table, M-op results, latency,
// start handshake and asynchronous reset during an operation.
module tb_alu_ctrl_muldiv;

  logic        clk;
  logic        reset;
  logic [1:0]  ALUOp;
  logic [2:0]  funct3;
  logic        op5, funct7_5, funct7_0, start;
  logic [31:0] a, b;
  logic [3:0]  ALUControl;
  logic [2:0]  load_store;
  logic        is_mop, md_busy, md_done;
  logic [31:0] md_result;

  int n_checks = 0;
  int n_fail   = 0;

  alu_ctrl_muldiv #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .ALUOp(ALUOp), .funct3(funct3), .op5(op5),
    .funct7_5(funct7_5), .funct7_0(funct7_0), .start(start), .a(a), .b(b),
    .ALUControl(ALUControl), .load_store(load_store), .is_mop(is_mop),
    .md_busy(md_busy), .md_done(md_done), .md_result(md_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic dec(input int idx, input logic [1:0] op, input logic [2:0] f3,
                     input logic o5, input logic f75, input logic f70,
                     input logic [3:0] exp_alu, input logic [2:0] exp_ls, input logic exp_mop);
    ALUOp = op; funct3 = f3; op5 = o5; funct7_5 = f75; funct7_0 = f70;
    #1;
    chk($sformatf("dec%0d_alu", idx), 32'(ALUControl), 32'(exp_alu));
    chk($sformatf("dec%0d_ls", idx), 32'(load_store), 32'(exp_ls));
    chk($sformatf("dec%0d_mop", idx), 32'(is_mop), 32'(exp_mop));
    $display("decode %0d: ALUOp=%b f3=%b op5=%b f7_5=%b f7_0=%b -> ALUControl=%b load_store=%b is_mop=%b",
             idx, op, f3, o5, f75, f70, ALUControl, load_store, is_mop);
  endtask

  task automatic launch(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    ALUOp = 2'b10; funct3 = f3; op5 = 1'b1; funct7_5 = 1'b0; funct7_0 = 1'b1;
    a = av; b = bv; start = 1'b1;
  endtask

  task automatic run_mop(input string tag, input logic [2:0] f3, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] exp_v);
    int n;
    launch(f3, av, bv);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk({tag, "_busy_run"}, 32'(md_busy), 32'd1);
    for (n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (md_done) break;
    end
    chk({tag, "_latency"}, 32'(n), 32'd33);
    chk({tag, "_done"}, 32'(md_done), 32'd1);
    chk({tag, "_busy_done"}, 32'(md_busy), 32'd0);
    chk({tag, "_result"}, md_result, exp_v);
    $display("mop %s: f3=%b a=%h b=%h -> result=%h after %0d cycles", tag, f3, av, bv, md_result, n);
    @(negedge clk);
    chk({tag, "_done_clr"}, 32'(md_done), 32'd0);
    chk({tag, "_hold"}, md_result, exp_v);
  endtask

  initial begin
    int ndone, first_n, second_n;
    reset = 1'b1; start = 1'b0; ALUOp = 2'b00; funct3 = 3'b000;
    op5 = 1'b0; funct7_5 = 1'b0; funct7_0 = 1'b0; a = '0; b = '0;
    #3;
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_done", 32'(md_done), 32'd0);
    chk("rst_result", md_result, 32'd0);
    $display("reset: busy=%b done=%b result=%h", md_busy, md_done, md_result);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    dec(1,  2'b00, 3'b000, 0, 0, 0, 4'b0000, 3'b001, 0);
    dec(2,  2'b00, 3'b001, 0, 0, 0, 4'b0000, 3'b010, 0);
    dec(3,  2'b00, 3'b010, 0, 0, 0, 4'b0000, 3'b000, 0);
    dec(4,  2'b00, 3'b100, 0, 0, 0, 4'b0000, 3'b011, 0);
    dec(5,  2'b00, 3'b101, 0, 0, 0, 4'b0000, 3'b100, 0);
    dec(6,  2'b00, 3'b011, 0, 0, 0, 4'b0000, 3'b000, 0);
    dec(7,  2'b01, 3'b000, 0, 0, 0, 4'b0001, 3'b000, 0);
    dec(8,  2'b11, 3'b101, 1, 1, 1, 4'b0000, 3'b000, 0);
    dec(9,  2'b10, 3'b000, 1, 1, 0, 4'b0001, 3'b000, 0);
    dec(10, 2'b10, 3'b000, 0, 1, 0, 4'b0000, 3'b000, 0);
    dec(11, 2'b10, 3'b001, 1, 0, 0, 4'b0010, 3'b000, 0);
    dec(12, 2'b10, 3'b010, 1, 0, 0, 4'b0011, 3'b000, 0);
    dec(13, 2'b10, 3'b011, 0, 0, 0, 4'b0100, 3'b000, 0);
    dec(14, 2'b10, 3'b100, 1, 0, 0, 4'b0101, 3'b000, 0);
    dec(15, 2'b10, 3'b101, 0, 1, 0, 4'b0110, 3'b000, 0);
    dec(16, 2'b10, 3'b101, 1, 1, 0, 4'b0111, 3'b000, 0);
    dec(17, 2'b10, 3'b110, 1, 0, 0, 4'b1000, 3'b000, 0);
    dec(18, 2'b10, 3'b111, 0, 0, 0, 4'b1001, 3'b000, 0);
    dec(19, 2'b10, 3'b000, 1, 0, 1, 4'b0000, 3'b000, 1);
    dec(20, 2'b10, 3'b111, 1, 0, 1, 4'b0000, 3'b000, 1);
    dec(21, 2'b10, 3'b101, 0, 0, 1, 4'b0110, 3'b000, 0);
    dec(22, 2'b00, 3'b000, 1, 0, 1, 4'b0000, 3'b001, 0);

    run_mop("mul",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
    run_mop("mulh",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
    run_mop("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_mop("mulhsu",  3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF);
    run_mop("div",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    run_mop("rem",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    run_mop("div2",    3'b100, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA);
    run_mop("rem2",    3'b110, 32'd20,       32'hFFFFFFFD, 32'd2);
    run_mop("divu_z",  3'b101, 32'd100,      32'd0,        32'hFFFFFFFF);
    run_mop("remu_z",  3'b111, 32'd100,      32'd0,        32'd100);
    run_mop("div_z",   3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF);
    run_mop("rem_z",   3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB);
    run_mop("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_mop("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0);
    run_mop("divu",    3'b101, 32'd1000,     32'd7,        32'd142);

    // start held for 40 edges: second op launches on the edge ending the first done cycle
    launch(3'b000, 32'd3, 32'd5);
    @(posedge clk);
    ndone = 0; first_n = 0; second_n = 0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk);
      if (n == 39) #1 start = 1'b0;
      @(negedge clk);
      if (md_done) begin
        ndone++;
        if (ndone == 1) first_n = n;
        else if (ndone == 2) second_n = n;
        chk($sformatf("hs_result%0d", ndone), md_result, 32'd15);
      end
      if (n == 33) chk("hs_busy_done", 32'(md_busy), 32'd0);
      if (n == 34) chk("hs_busy_second", 32'(md_busy), 32'd1);
    end
    chk("hs_count", 32'(ndone), 32'd2);
    chk("hs_first", 32'(first_n), 32'd33);
    chk("hs_second", 32'(second_n), 32'd67);
    $display("handshake: %0d results at cycles %0d and %0d", ndone, first_n, second_n);

    @(negedge clk);
    ALUOp = 2'b10; funct3 = 3'b000; op5 = 1'b1; funct7_0 = 1'b0; start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ign_busy", 32'(md_busy), 32'd0);
    chk("ign_done", 32'(md_done), 32'd0);
    chk("ign_mop", 32'(is_mop), 32'd0);
    $display("ignored start: busy=%b done=%b", md_busy, md_done);
    start = 1'b0;

    // asynchronous reset partway through a divide
    launch(3'b101, 32'd1000, 32'd7);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mrst_busy", 32'(md_busy), 32'd0);
    chk("mrst_done", 32'(md_done), 32'd0);
    chk("mrst_result", md_result, 32'd0);
    $display("mid-op reset: busy=%b done=%b result=%h", md_busy, md_done, md_result);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (md_done) ndone++;
    end
    chk("mrst_no_done", 32'(ndone), 32'd0);
    run_mop("after_rst", 3'b100, 32'd1000, 32'd7, 32'd142);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
